rv_hazard_ctrl: RTL

- Control-side counterpart of the EX-stage operand forwarding mux in the 5-stage RV32I pipeline.
- Tracks destination/source register tags as instructions move D→E→M→W.
- Generates the 2-bit forwarding selects (00 none, 01 WB→EX, 10 MEM→EX) consumed by the EX operand mux.
- Also generates load-use stalls, taken-branch flushes and data-memory-wait freezes for all pipeline registers.

---
 rtl/rv_hazard_ctrl.sv | 69 ++++++
 1 files changed

// File: rtl/rv_hazard_ctrl.sv
// rv_hazard_ctrl: tag pipeline producing forwarding selects, load-use stalls, branch flushes and memory-wait freezes.
module rv_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] rdD,
  input  logic                      reg_writeD,
  input  logic                      mem_readD,
  input  logic                      branch_takenE,
  input  logic                      mem_wait,
  output logic [1:0]                forward_rs1E,
  output logic [1:0]                forward_rs2E,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      stallE,
  output logic                      stallM,
  output logic                      stallW,
  output logic                      flushD,
  output logic                      flushE
);
  localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;
  logic [REG_ADDR_WIDTH-1:0] rs1E, rs2E, rdE, rdM, rdW;
  logic reg_writeE, mem_readE, reg_writeM, mem_readM, reg_writeW;
  logic lu;
  // A load in M cannot forward: its data only exists once it reaches W.
  function automatic logic [1:0] fwd(input logic [REG_ADDR_WIDTH-1:0] rs, rd_m, rd_w,
                                     input logic rw_m, mr_m, rw_w);
    return (rw_m && rd_m != X0 && rd_m == rs && !mr_m) ? 2'b10 :
           (rw_w && rd_w != X0 && rd_w == rs)          ? 2'b01 : 2'b00;
  endfunction
  assign lu = mem_readE & reg_writeE & (rdE != X0) & ((rdE == rs1D) | (rdE == rs2D));
  assign forward_rs1E = rst ? 2'b00 : fwd(rs1E, rdM, rdW, reg_writeM, mem_readM, reg_writeW);
  assign forward_rs2E = rst ? 2'b00 : fwd(rs2E, rdM, rdW, reg_writeM, mem_readM, reg_writeW);
  assign stallF = !rst & (mem_wait | (!branch_takenE & lu));
  assign stallD = stallF;
  assign stallE = !rst & mem_wait;
  assign stallM = stallE;
  assign stallW = stallE;
  assign flushD = !rst & !mem_wait & branch_takenE;
  assign flushE = !rst & !mem_wait & (branch_takenE | lu);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1E       <= '0;
      rs2E       <= '0;
      rdE        <= '0;
      reg_writeE <= 1'b0;
      mem_readE  <= 1'b0;
      rdM        <= '0;
      reg_writeM <= 1'b0;
      mem_readM  <= 1'b0;
      rdW        <= '0;
      reg_writeW <= 1'b0;
    end else if (!mem_wait) begin
      rdW        <= rdM;
      reg_writeW <= reg_writeM;
      rdM        <= rdE;
      reg_writeM <= reg_writeE;
      mem_readM  <= mem_readE;
      rs1E       <= flushE ? '0 : rs1D;
      rs2E       <= flushE ? '0 : rs2D;
      rdE        <= flushE ? '0 : rdD;
      reg_writeE <= flushE ? 1'b0 : reg_writeD;
      mem_readE  <= flushE ? 1'b0 : mem_readD;
    end
  end
endmodule
